// File: rtl/region_arb_pkg.sv
// Shared types for the region read arbiter: FSM states, requester index and
// the {valid, idx} tag that follows each BRAM read to its requester.
package region_arb_pkg;

    localparam int MAX_NUM_REQ = 8;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

    typedef logic [2:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } tag_t;

endpackage

// File: rtl/region_arb_tagpipe.sv
// Tag shift register matched to the BRAM read latency; at the last stage it
// registers the read data and raises the issuing requester's valid bit.
module region_arb_tagpipe
    import region_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 512,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  tag_t               i_tag,
    input  logic [WIDTH-1:0]   i_rdata,
    output logic [NUM_REQ-1:0] o_rvalid,
    output logic [WIDTH-1:0]   o_rdata
);

    tag_t               r_pipe [READ_LATENCY];
    tag_t               w_head;
    logic [NUM_REQ-1:0] w_onehot;

    assign w_head = r_pipe[READ_LATENCY-1];

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_onehot[i] = w_head.valid && (w_head.idx == req_idx_t'(i));
        end
    end

    // Reset drops every in-flight tag so no stale valid escapes afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
            o_rvalid <= '0;
            o_rdata  <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            o_rvalid <= w_onehot;
            if (w_head.valid) begin
                o_rdata <= i_rdata;
            end
        end
    end

endmodule

// File: rtl/region_read_arbiter.sv
// Round-robin, burst-limited arbiter sharing one region BRAM read port.
// Optional per-requester grant/stall counters: define REGION_ARB_STATS_EN.
module region_read_arbiter
    import region_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 512,
    parameter int LOG2_DEPTH   = 10,
    parameter int READ_LATENCY = 2,
    parameter int MAX_BURST    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LOG2_DEPTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_almostfull,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          bram_re,
    output logic [LOG2_DEPTH-1:0]         bram_raddr,
    input  logic [WIDTH-1:0]              bram_rdata,
    output logic [NUM_REQ-1:0]            out_rvalid,
    output logic [WIDTH-1:0]              out_rdata
`ifdef REGION_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stat_grants,
    output logic [NUM_REQ*32-1:0]         stat_stalls
`endif
);

    arb_state_t         r_state, w_next_state;
    req_idx_t           r_owner, w_next_owner;
    req_idx_t           r_rr_ptr, w_next_ptr;
    logic [7:0]         r_burst_cnt, w_next_burst;
    logic               r_run;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_owner_elig;
    req_idx_t           w_owner_inc;
    req_idx_t           w_start;
    req_idx_t           w_pick;
    logic               w_found;
    logic               w_keep;
    req_idx_t           w_winner;
    logic               w_do_grant;
    tag_t               w_tag;

    assign w_elig      = req & ~req_almostfull;
    assign w_owner_inc = (r_owner == req_idx_t'(NUM_REQ-1)) ? '0 : r_owner + 3'd1;
    assign w_start     = (r_state == OWN) ? w_owner_inc : r_rr_ptr;
    assign w_keep      = (r_state == OWN) && w_owner_elig && (r_burst_cnt < 8'(MAX_BURST));

    // First eligible requester at or after w_start, scanning with wrap.
    always_comb begin
        w_found      = 1'b0;
        w_pick       = '0;
        w_owner_elig = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == req_idx_t'(i)) begin
                w_owner_elig = w_elig[i];
            end
        end
        for (int s = 0; s < NUM_REQ; s++) begin
            if (w_start == req_idx_t'(s)) begin
                for (int k = NUM_REQ-1; k >= 0; k--) begin
                    if (w_elig[(s+k) % NUM_REQ]) begin
                        w_found = 1'b1;
                        w_pick  = req_idx_t'((s+k) % NUM_REQ);
                    end
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_ptr   = r_rr_ptr;
        w_next_burst = r_burst_cnt;
        w_winner     = '0;
        w_do_grant   = 1'b0;
        if (w_keep) begin
            w_winner     = r_owner;
            w_do_grant   = 1'b1;
            w_next_burst = r_burst_cnt + 8'd1;
        end else begin
            if (r_state == OWN) begin
                w_next_ptr = w_owner_inc;
            end
            if (w_found) begin
                w_winner     = w_pick;
                w_do_grant   = 1'b1;
                w_next_state = OWN;
                w_next_owner = w_pick;
                w_next_burst = 8'd1;
            end else begin
                w_next_state = IDLE;
                w_next_burst = 8'd0;
            end
        end
    end

    // r_run keeps grants off while reset is low without routing reset into logic.
    always_comb begin
        grant      = '0;
        bram_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_do_grant && r_run && (w_winner == req_idx_t'(i))) begin
                grant[i]   = 1'b1;
                bram_raddr = req_addr[i*LOG2_DEPTH +: LOG2_DEPTH];
            end
        end
    end

    assign bram_re   = w_do_grant && r_run;
    assign w_tag     = '{valid: bram_re, idx: w_winner};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_state     <= w_next_state;
                r_owner     <= w_next_owner;
                r_rr_ptr    <= w_next_ptr;
                r_burst_cnt <= w_next_burst;
            end
        end
    end

    region_arb_tagpipe #(
        .NUM_REQ      (NUM_REQ),
        .WIDTH        (WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_tagpipe (
        .clk      (clk),
        .reset    (reset),
        .i_tag    (w_tag),
        .i_rdata  (bram_rdata),
        .o_rvalid (out_rvalid),
        .o_rdata  (out_rdata)
    );

`ifdef REGION_ARB_STATS_EN
    logic [31:0] r_stat_grants [NUM_REQ];
    logic [31:0] r_stat_stalls [NUM_REQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_grants[i] <= '0;
                r_stat_stalls[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
                end
                if (req[i] && !grant[i]) begin
                    r_stat_stalls[i] <= r_stat_stalls[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign stat_grants[g*32 +: 32] = r_stat_grants[g];
        assign stat_stalls[g*32 +: 32] = r_stat_stalls[g];
    end
`endif

endmodule

// File: tb/tb_region_read_arbiter.sv
// Directed bench for region_read_arbiter (4 requesters, latency 2, burst 8);
// stats checks are compiled in when REGION_ARB_STATS_EN is defined.
module tb_region_read_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int AW = 10;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0] req_almostfull;
    logic [NR-1:0] grant;
    logic          bram_re;
    logic [AW-1:0] bram_raddr;
    logic [W-1:0]  bram_rdata;
    logic [NR-1:0] out_rvalid;
    logic [W-1:0]  out_rdata;
`ifdef REGION_ARB_STATS_EN
    logic [NR*32-1:0] stat_grants;
    logic [NR*32-1:0] stat_stalls;
`endif

    logic [W-1:0] bramStage;
    int checks = 0;
    int errors = 0;

    region_read_arbiter #(
        .NUM_REQ      (NR),
        .WIDTH        (W),
        .LOG2_DEPTH   (AW),
        .READ_LATENCY (2),
        .MAX_BURST    (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_addr       (req_addr),
        .req_almostfull (req_almostfull),
        .grant          (grant),
        .bram_re        (bram_re),
        .bram_raddr     (bram_raddr),
        .bram_rdata     (bram_rdata),
        .out_rvalid     (out_rvalid),
        .out_rdata      (out_rdata)
`ifdef REGION_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_stalls    (stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle BRAM model: data word is 0xD0000000 | address.
    always @(posedge clk) begin
        bramStage  <= 32'hD000_0000 | 32'(bram_raddr);
        bram_rdata <= bramStage;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] af);
        req            = r;
        req_almostfull = af;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [NR-1:0] expGrant;
        reset          = 1'b0;
        req            = '0;
        req_addr       = '0;
        req_almostfull = '0;
        bram_rdata     = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with requests driven to show outputs stay quiet.
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_re", 32'(bram_re), 32'h0);
        checkOutput("rst_raddr", 32'(bram_raddr), 32'h0);
        checkOutput("rst_rvalid", 32'(out_rvalid), 32'h0);
        checkOutput("rst_rdata", out_rdata, 32'h0);
        req = '0;
        advance();
        reset = 1'b1;
        advance();

        // Single requester, addresses 5,6,7.
        req_addr[0*AW +: AW] = 10'd5;
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("single_g0", 32'(grant), 32'h1);
        checkOutput("single_re0", 32'(bram_re), 32'h1);
        checkOutput("single_a0", 32'(bram_raddr), 32'd5);
        advance();
        req_addr[0*AW +: AW] = 10'd6;
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("single_g1", 32'(grant), 32'h1);
        checkOutput("single_a1", 32'(bram_raddr), 32'd6);
        advance();
        req_addr[0*AW +: AW] = 10'd7;
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("single_g2", 32'(grant), 32'h1);
        checkOutput("single_a2", 32'(bram_raddr), 32'd7);
        advance();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("single_g3", 32'(grant), 32'h0);
        checkOutput("single_re3", 32'(bram_re), 32'h0);
        checkOutput("single_v3", 32'(out_rvalid), 32'h1);
        checkOutput("single_d3", out_rdata, 32'hD000_0005);
        advance();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("single_v4", 32'(out_rvalid), 32'h1);
        checkOutput("single_d4", out_rdata, 32'hD000_0006);
        advance();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("single_v5", 32'(out_rvalid), 32'h1);
        checkOutput("single_d5", out_rdata, 32'hD000_0007);
        advance();
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("single_v6", 32'(out_rvalid), 32'h0);
        advance();

        // Burst limit; pointer now sits at 1 after requester 0 went idle.
        req_addr[0*AW +: AW] = 10'h010;
        req_addr[1*AW +: AW] = 10'h020;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(4'b0011, 4'b0000);
            expGrant = (k < 8 || k >= 16) ? 4'b0010 : 4'b0001;
            checkOutput($sformatf("burst_g%0d", k), 32'(grant), 32'(expGrant));
            checkOutput($sformatf("burst_a%0d", k), 32'(bram_raddr),
                        (k < 8 || k >= 16) ? 32'h020 : 32'h010);
            advance();
        end
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("burst_end", 32'(grant), 32'h0);
        advance();

        // Backpressure on requester 2.
        req_addr[2*AW +: AW] = 10'h030;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0100, 4'b0000);
            checkOutput($sformatf("bp_g%0d", k), 32'(grant), 32'h4);
            advance();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0100, 4'b0100);
            checkOutput($sformatf("bp_stall_g%0d", k), 32'(grant), 32'h0);
            checkOutput($sformatf("bp_stall_re%0d", k), 32'(bram_re), 32'h0);
            advance();
        end
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("bp_resume", 32'(grant), 32'h4);
        checkOutput("bp_resume_a", 32'(bram_raddr), 32'h030);
        advance();
        applyStimulus(4'b0000, 4'b0000);
        advance();

        // Wrap: pointer is 3, requester 3 bursts then 0 takes over.
        req_addr[3*AW +: AW] = 10'h3FF;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1001, 4'b0000);
            checkOutput($sformatf("wrap_g%0d", k), 32'(grant), 32'h8);
            checkOutput($sformatf("wrap_a%0d", k), 32'(bram_raddr), 32'h3FF);
            advance();
        end
        applyStimulus(4'b1001, 4'b0000);
        checkOutput("wrap_next", 32'(grant), 32'h1);
        checkOutput("wrap_next_a", 32'(bram_raddr), 32'h010);
        advance();

        // Two reads in flight to requester 1, then async reset.
        req_addr[1*AW +: AW] = 10'h021;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0010, 4'b0000);
            checkOutput($sformatf("flight_g%0d", k), 32'(grant), 32'h2);
            advance();
        end
        reset = 1'b0;
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("midrst_grant", 32'(grant), 32'h0);
        checkOutput("midrst_re", 32'(bram_re), 32'h0);
        checkOutput("midrst_raddr", 32'(bram_raddr), 32'h0);
        checkOutput("midrst_rvalid", 32'(out_rvalid), 32'h0);
        checkOutput("midrst_rdata", out_rdata, 32'h0);
        advance();
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("midrst_grant2", 32'(grant), 32'h0);
        checkOutput("midrst_rvalid2", 32'(out_rvalid), 32'h0);
        advance();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 4'b0000);
            checkOutput($sformatf("postrst_v%0d", k), 32'(out_rvalid), 32'h0);
            advance();
        end
        applyStimulus(4'b0011, 4'b0000);
        checkOutput("postrst_first", 32'(grant), 32'h1);
        advance();
        applyStimulus(4'b0000, 4'b0000);
        advance();

`ifdef REGION_ARB_STATS_EN
        // Ten grants to requester 1 while requester 2 waits five cycles.
        reset = 1'b0;
        advance();
        reset = 1'b1;
        advance();
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k >= 3 && k < 8) ? 4'b0110 : 4'b0010, 4'b0000);
            checkOutput($sformatf("stat_g%0d", k), 32'(grant), 32'h2);
            advance();
        end
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("stat_grants1", stat_grants[1*32 +: 32], 32'd10);
        checkOutput("stat_stalls2", stat_stalls[2*32 +: 32], 32'd5);
        checkOutput("stat_stalls1", stat_stalls[1*32 +: 32], 32'd0);
        checkOutput("stat_grants2", stat_grants[2*32 +: 32], 32'd0);
        advance();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
